// File: rtl/llc_snoop_responder_pkg.sv
// Shared bus-operation and snoop-result types for the LLC snoop responder,
// plus the address-to-snoop-result mapping used by the responder FSM.
package LLC_defs;

    localparam int LLC_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } busOperation;

    typedef enum logic [1:0] {
        NOHIT = 2'd0,
        HIT   = 2'd1,
        HITM  = 2'd2
    } snoopResults;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FLUSH,
        ST_RESP
    } rsp_state_t;

    // The other caches' state is modelled from the two low address bits.
    function automatic snoopResults snoop_result(input busOperation op, input logic [1:0] a);
        snoopResults r;
        case (a)
            2'b00:   r = HIT;
            2'b01:   r = HITM;
            default: r = NOHIT;
        endcase
        if (op == WRITE) begin
            r = NOHIT;
        end else if (op == INVALIDATE && r == HITM) begin
            r = HIT;
        end
        return r;
    endfunction

endpackage

// File: rtl/llc_snoop_responder_if.sv
// Bus between the LLC (master) and the snoop responder (slave): request
// handshake, snoop response, flush beats and the illegal-operation pulse.
interface llc_snoop_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    import LLC_defs::*;

    logic                  req_valid;
    logic                  req_ready;
    busOperation           req_busOp;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    snoopResults           rsp_snoopResult;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  flush_valid;
    logic [3:0]            flush_beat;
    logic                  err_illegal;

    modport master (
        output req_valid, req_busOp, req_addr,
        input  req_ready, rsp_valid, rsp_snoopResult, rsp_addr,
        input  flush_valid, flush_beat, err_illegal
    );

    modport slave (
        input  req_valid, req_busOp, req_addr,
        output req_ready, rsp_valid, rsp_snoopResult, rsp_addr,
        output flush_valid, flush_beat, err_illegal
    );

endinterface

// File: rtl/llc_snoop_responder_sat_counter.sv
// Statistics counter that increments on inc and sticks at all-ones.
module llc_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/llc_snoop_responder.sv
// Models the other processors' caches: takes one LLC bus operation at a time,
// returns its snoop result after a fixed latency and drives HITM flush beats.
module llc_snoop_responder
    import LLC_defs::*;
#(
    parameter int ADDR_WIDTH   = LLC_ADDR_WIDTH,
    parameter int RESP_LATENCY = 2,
    parameter int FLUSH_BEATS  = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    llc_snoop_responder_if.slave bus,
    output logic [CNT_WIDTH-1:0] cnt_reads,
    output logic [CNT_WIDTH-1:0] cnt_writes,
    output logic [CNT_WIDTH-1:0] cnt_invals,
    output logic [CNT_WIDTH-1:0] cnt_rwims,
    output logic [CNT_WIDTH-1:0] cnt_hitm
);

    localparam int NUM_CNT = 5;
    localparam int CNT_HITM_IDX = 4;

    rsp_state_t            state_q, state_d;
    busOperation           op_q, op_d;
    snoopResults           result_q, result_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wait_q, wait_d;
    logic [3:0]            beat_q, beat_d;
    logic                  flush_valid_q, flush_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  err_q, err_d;
    logic [NUM_CNT-1:0]    inc;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        result_d      = result_q;
        addr_d        = addr_q;
        wait_d        = wait_q;
        beat_d        = beat_q;
        flush_valid_d = 1'b0;
        rsp_valid_d   = 1'b0;
        err_d         = 1'b0;
        inc           = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    // Legal ops select their statistics counter; anything else is rejected.
                    case (bus.req_busOp)
                        READ:       inc[0] = 1'b1;
                        WRITE:      inc[1] = 1'b1;
                        INVALIDATE: inc[2] = 1'b1;
                        RWIM:       inc[3] = 1'b1;
                        default:    err_d  = 1'b1;
                    endcase
                    if (!err_d) begin
                        op_d     = bus.req_busOp;
                        addr_d   = bus.req_addr;
                        result_d = snoop_result(bus.req_busOp, bus.req_addr[1:0]);
                        wait_d   = 4'(RESP_LATENCY - 1);
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    if (result_q == HITM && (op_q == READ || op_q == RWIM)) begin
                        state_d             = ST_FLUSH;
                        flush_valid_d       = 1'b1;
                        beat_d              = 4'd0;
                        inc[CNT_HITM_IDX]   = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_FLUSH: begin
                if (beat_q == 4'(FLUSH_BEATS - 1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    beat_d      = 4'd0;
                end else begin
                    flush_valid_d = 1'b1;
                    beat_d        = beat_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= READ;
            result_q      <= NOHIT;
            addr_q        <= '0;
            wait_q        <= 4'd0;
            beat_q        <= 4'd0;
            flush_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            result_q      <= result_d;
            addr_q        <= addr_d;
            wait_q        <= wait_d;
            beat_q        <= beat_d;
            flush_valid_q <= flush_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            err_q         <= err_d;
        end
    end

    // Gated by rst so nothing can be accepted while reset is held.
    assign bus.req_ready       = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_snoopResult = result_q;
    assign bus.rsp_addr        = addr_q;
    assign bus.flush_valid     = flush_valid_q;
    assign bus.flush_beat      = beat_q;
    assign bus.err_illegal     = err_q;

    logic [CNT_WIDTH-1:0] cnt_vals [NUM_CNT];

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        llc_sat_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[gi]),
            .count(cnt_vals[gi])
        );
    end

    assign cnt_reads  = cnt_vals[0];
    assign cnt_writes = cnt_vals[1];
    assign cnt_invals = cnt_vals[2];
    assign cnt_rwims  = cnt_vals[3];
    assign cnt_hitm   = cnt_vals[CNT_HITM_IDX];

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed bench for llc_snoop_responder: a 32-bit-counter instance and a
// 2-bit-counter instance share one stimulus stream.
module tb_llc_snoop_responder;
    import LLC_defs::*;

    localparam int L = 2;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    llc_snoop_responder_if #(.ADDR_WIDTH(32)) bus1 ();
    llc_snoop_responder_if #(.ADDR_WIDTH(32)) bus2 ();

    logic [31:0] c1_reads, c1_writes, c1_invals, c1_rwims, c1_hitm;
    logic [1:0]  c2_reads, c2_writes, c2_invals, c2_rwims, c2_hitm;

    llc_snoop_responder #(
        .ADDR_WIDTH(32), .RESP_LATENCY(L), .FLUSH_BEATS(F), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus1),
        .cnt_reads(c1_reads), .cnt_writes(c1_writes), .cnt_invals(c1_invals),
        .cnt_rwims(c1_rwims), .cnt_hitm(c1_hitm)
    );

    llc_snoop_responder #(
        .ADDR_WIDTH(32), .RESP_LATENCY(L), .FLUSH_BEATS(F), .CNT_WIDTH(2)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .cnt_reads(c2_reads), .cnt_writes(c2_writes), .cnt_invals(c2_invals),
        .cnt_rwims(c2_rwims), .cnt_hitm(c2_hitm)
    );

    int total = 0;
    int bad   = 0;
    int m_reads = 0, m_writes = 0, m_invals = 0, m_rwims = 0, m_hitm = 0;

    typedef struct {
        busOperation op;
        logic [31:0] addr;
        snoopResults exp_res;
        bit          exp_flush;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive_req(input logic v, input busOperation op, input logic [31:0] addr);
        bus1.req_valid = v; bus1.req_busOp = op; bus1.req_addr = addr;
        bus2.req_valid = v; bus2.req_busOp = op; bus2.req_addr = addr;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, ".cnt_reads"},  c1_reads,  m_reads);
        chk({tag, ".cnt_writes"}, c1_writes, m_writes);
        chk({tag, ".cnt_invals"}, c1_invals, m_invals);
        chk({tag, ".cnt_rwims"},  c1_rwims,  m_rwims);
        chk({tag, ".cnt_hitm"},   c1_hitm,   m_hitm);
        chk({tag, ".sat_reads"},  32'(c2_reads),  sat3(m_reads));
        chk({tag, ".sat_writes"}, 32'(c2_writes), sat3(m_writes));
        chk({tag, ".sat_invals"}, 32'(c2_invals), sat3(m_invals));
        chk({tag, ".sat_rwims"},  32'(c2_rwims),  sat3(m_rwims));
        chk({tag, ".sat_hitm"},   32'(c2_hitm),   sat3(m_hitm));
    endtask

    // Called at a negedge with req_ready high; returns at the negedge where
    // req_ready is high again, having checked every cycle in between.
    task automatic run_op(input busOperation op, input logic [31:0] addr,
                          input snoopResults exp_res, input bit exp_flush, input string tag);
        int rsp_k;
        rsp_k = exp_flush ? L + F : L;
        chk({tag, ".ready_pre"}, 32'(bus1.req_ready), 1);
        drive_req(1'b1, op, addr);
        @(posedge clk);
        #1;
        drive_req(1'b0, op, addr);
        case (op)
            READ:       m_reads++;
            WRITE:      m_writes++;
            INVALIDATE: m_invals++;
            default:    m_rwims++;
        endcase
        if (exp_flush) m_hitm++;
        for (int k = 0; k <= rsp_k + 1; k++) begin
            @(negedge clk);
            chk({tag, ".rsp_valid"},   32'(bus1.rsp_valid), 32'(k == rsp_k));
            chk({tag, ".rsp_valid2"},  32'(bus2.rsp_valid), 32'(k == rsp_k));
            chk({tag, ".flush_valid"}, 32'(bus1.flush_valid),
                32'(exp_flush && k >= L && k < L + F));
            if (exp_flush && k >= L && k < L + F)
                chk({tag, ".flush_beat"}, 32'(bus1.flush_beat), 32'(k - L));
            chk({tag, ".req_ready"}, 32'(bus1.req_ready), 32'(k == rsp_k + 1));
            if (k == rsp_k) begin
                chk({tag, ".result"},   32'(bus1.rsp_snoopResult), 32'(exp_res));
                chk({tag, ".rsp_addr"}, bus1.rsp_addr, addr);
            end
        end
        check_counters(tag);
        $display("txn %s op=%0d addr=%08h expected_result=%0d flush=%0d", tag, op, addr, exp_res, exp_flush);
    endtask

    initial begin
        drive_req(1'b0, READ, 32'h0);

        vecs[0] = '{READ,       32'h0000_1000, HIT,   1'b0};
        vecs[1] = '{READ,       32'h0000_1001, HITM,  1'b1};
        vecs[2] = '{INVALIDATE, 32'h0000_2001, HIT,   1'b0};
        vecs[3] = '{WRITE,      32'h0000_3001, NOHIT, 1'b0};
        vecs[4] = '{RWIM,       32'h0000_4000, HIT,   1'b0};
        vecs[5] = '{RWIM,       32'h0000_4001, HITM,  1'b1};
        vecs[6] = '{READ,       32'h0000_5003, NOHIT, 1'b0};
        vecs[7] = '{INVALIDATE, 32'h0000_6000, HIT,   1'b0};
        vecs[8] = '{WRITE,      32'h0000_7000, NOHIT, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.req_ready",   32'(bus1.req_ready), 0);
        chk("rst.rsp_valid",   32'(bus1.rsp_valid), 0);
        chk("rst.result",      32'(bus1.rsp_snoopResult), 32'(NOHIT));
        chk("rst.rsp_addr",    bus1.rsp_addr, 0);
        chk("rst.flush_valid", 32'(bus1.flush_valid), 0);
        chk("rst.flush_beat",  32'(bus1.flush_beat), 0);
        chk("rst.err",         32'(bus1.err_illegal), 0);
        check_counters("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.req_ready", 32'(bus1.req_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].exp_res, vecs[i].exp_flush, $sformatf("vec%0d", i));
        end

        // Illegal operations: one-cycle error pulse, no state or counter change
        for (int j = 0; j < 2; j++) begin
            logic [2:0] bad_op;
            bad_op = (j == 0) ? 3'd0 : 3'd5;
            drive_req(1'b1, busOperation'(bad_op), 32'h0000_1000);
            @(posedge clk);
            #1;
            drive_req(1'b0, READ, 32'h0);
            @(negedge clk);
            chk("illegal.err_pulse", 32'(bus1.err_illegal), 1);
            chk("illegal.req_ready", 32'(bus1.req_ready), 1);
            chk("illegal.rsp_valid", 32'(bus1.rsp_valid), 0);
            @(negedge clk);
            chk("illegal.err_clear", 32'(bus1.err_illegal), 0);
            chk("illegal.req_ready2", 32'(bus1.req_ready), 1);
            check_counters("illegal");
            $display("txn illegal op=%0d", bad_op);
        end

        // Reset during flush beat 1 of a HITM RWIM
        drive_req(1'b1, RWIM, 32'h0000_4005);
        @(posedge clk);
        #1;
        drive_req(1'b0, READ, 32'h0);
        for (int k = 0; k <= L + 1; k++) @(negedge clk);
        chk("rstflush.beat1_valid", 32'(bus1.flush_valid), 1);
        chk("rstflush.beat1_idx",   32'(bus1.flush_beat), 1);
        rst = 1'b1;
        m_reads = 0; m_writes = 0; m_invals = 0; m_rwims = 0; m_hitm = 0;
        @(negedge clk);
        chk("rstflush.flush_valid", 32'(bus1.flush_valid), 0);
        chk("rstflush.flush_beat",  32'(bus1.flush_beat), 0);
        chk("rstflush.rsp_valid",   32'(bus1.rsp_valid), 0);
        chk("rstflush.req_ready",   32'(bus1.req_ready), 0);
        chk("rstflush.result",      32'(bus1.rsp_snoopResult), 32'(NOHIT));
        chk("rstflush.rsp_addr",    bus1.rsp_addr, 0);
        check_counters("rstflush");
        // Request presented while reset is held must be ignored
        drive_req(1'b1, READ, 32'h0000_1000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_req(1'b0, READ, 32'h0);
        for (int k = 0; k <= L + F + 1; k++) begin
            @(negedge clk);
            chk("rstvalid.rsp_valid",   32'(bus1.rsp_valid), 0);
            chk("rstvalid.flush_valid", 32'(bus1.flush_valid), 0);
            chk("rstvalid.req_ready",   32'(bus1.req_ready), 1);
        end
        check_counters("rstvalid");
        $display("txn reset_during_flush and request_during_reset");

        // Saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            run_op(READ, 32'h0000_7002, NOHIT, 1'b0, $sformatf("sat%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
